// File: rtl/axi_slave_wr_buffer_mem.sv
// Write buffer FIFO draining into a byte-strobed register memory, with a single-port read path.
// Optional macro WR_BUF_RAW_ORDER_EN: reads wait until all earlier writes have reached memory.
module axi_slave_wr_buffer_mem #(
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int DATA_MEM_LENGTH   = 16,
  parameter int OPT_MEM_ADDR_BITS = $clog2(DATA_MEM_LENGTH),
  parameter int ADDR_LSB          = $clog2(AXI_DATA_WIDTH/8),
  parameter int ADDR_BASE_OFFSET  = 0,
  parameter int FIFO_DEPTH        = 16,
  parameter int MAX_BURST         = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [AXI_DATA_WIDTH-1:0]          write_data,
  input  logic [3:0]                         write_strb,
  input  logic [AXI_ADDR_WIDTH-1:0]          w_opt_addr,
  input  logic                               write_valid,
  output logic                               aw_ar_ready,
  input  logic                               rd_en,
  input  logic [AXI_ADDR_WIDTH-1:0]          rd_addr,
  output logic                               rd_ready,
  output logic [AXI_DATA_WIDTH-1:0]          rd_data,
  output logic                               rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               overflow,
  output logic [7:0]                         drop_cnt
);

  localparam int LW    = $clog2(FIFO_DEPTH+1);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NLANE = (AXI_DATA_WIDTH/8 < 4) ? AXI_DATA_WIDTH/8 : 4;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE_WORD = AXI_ADDR_WIDTH'(ADDR_BASE_OFFSET >> ADDR_LSB);
  localparam logic [AXI_ADDR_WIDTH-1:0] MEM_LEN   = AXI_ADDR_WIDTH'(DATA_MEM_LENGTH);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
  // Highest post-update level that still leaves room for a full burst plus the write-stage pipeline slot
  localparam logic [LW-1:0] READY_LEVEL = LW'(FIFO_DEPTH - MAX_BURST - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  state_t                      state_r;
  logic [PW-1:0]               wr_ptr_r;
  logic [PW-1:0]               rd_ptr_r;
  logic [LW-1:0]               level_r;
  logic [AXI_ADDR_WIDTH-1:0]   fifo_idx_r  [FIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0]   fifo_data_r [FIFO_DEPTH];
  logic [3:0]                  fifo_strb_r [FIFO_DEPTH];
  logic [AXI_DATA_WIDTH-1:0]   mem_r       [DATA_MEM_LENGTH];
  logic                        overflow_r;
  logic [7:0]                  drop_cnt_r;
  logic                        aw_ar_ready_r;
  logic [AXI_DATA_WIDTH-1:0]   rd_data_r;
  logic                        rd_valid_r;

  logic                        rd_ready_s;
  logic                        rd_accept_s;
  logic                        pop_s;
  logic                        push_s;
  logic [LW-1:0]               level_next_s;
  logic [AXI_ADDR_WIDTH-1:0]   wr_idx_s;
  logic [AXI_ADDR_WIDTH-1:0]   rd_idx_s;
  logic [AXI_ADDR_WIDTH-1:0]   pop_idx_s;
  logic [AXI_DATA_WIDTH-1:0]   pop_data_s;
  logic [3:0]                  pop_strb_s;
  logic                        pop_in_range_s;
  logic                        rd_in_range_s;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH-1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Read acceptance, pop/push decisions and next FIFO level
  always_comb begin
`ifdef WR_BUF_RAW_ORDER_EN
    rd_ready_s = (level_r == {LW{1'b0}}) && (state_r == ST_IDLE);
`else
    rd_ready_s = 1'b1;
`endif
    rd_accept_s    = rd_en && rd_ready_s;
    pop_s          = (state_r == ST_DRAIN) && (level_r != {LW{1'b0}}) && !rd_accept_s;
    push_s         = write_valid && ((level_r < FULL_LEVEL) || pop_s);
    level_next_s   = level_r + LW'(push_s) - LW'(pop_s);
    wr_idx_s       = w_opt_addr - BASE_WORD;
    rd_idx_s       = rd_addr - BASE_WORD;
    pop_idx_s      = fifo_idx_r[rd_ptr_r];
    pop_data_s     = fifo_data_r[rd_ptr_r];
    pop_strb_s     = fifo_strb_r[rd_ptr_r];
    pop_in_range_s = (pop_idx_s < MEM_LEN);
    rd_in_range_s  = (rd_idx_s < MEM_LEN);
  end

  // Drain state machine; an accepted read takes the memory port and parks the drain in STALL
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_r != {LW{1'b0}}) state_r <= ST_DRAIN;
          else                       state_r <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (rd_accept_s)                         state_r <= ST_STALL;
          else if (level_next_s == {LW{1'b0}})     state_r <= ST_IDLE;
          else                                     state_r <= ST_DRAIN;
        end
        ST_STALL: begin
          if (rd_accept_s)                   state_r <= ST_STALL;
          else if (level_r != {LW{1'b0}})    state_r <= ST_DRAIN;
          else                               state_r <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy, status flags and burst admission
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      level_r       <= {LW{1'b0}};
      overflow_r    <= 1'b0;
      drop_cnt_r    <= 8'd0;
      aw_ar_ready_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= next_ptr(wr_ptr_r);
      if (pop_s)  rd_ptr_r <= next_ptr(rd_ptr_r);
      level_r <= level_next_s;
      if (write_valid && !push_s) overflow_r <= 1'b1;
      if (pop_s && !pop_in_range_s && (drop_cnt_r != 8'hFF)) drop_cnt_r <= drop_cnt_r + 8'd1;
      aw_ar_ready_r <= (level_next_s <= READY_LEVEL);
    end
  end

  // FIFO entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_idx_r[i]  <= {AXI_ADDR_WIDTH{1'b0}};
        fifo_data_r[i] <= {AXI_DATA_WIDTH{1'b0}};
        fifo_strb_r[i] <= 4'd0;
      end
    end else if (push_s) begin
      fifo_idx_r[wr_ptr_r]  <= wr_idx_s;
      fifo_data_r[wr_ptr_r] <= write_data;
      fifo_strb_r[wr_ptr_r] <= write_strb;
    end
  end

  // Register memory, byte-lane writes from the drained entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_MEM_LENGTH; i++) begin
        mem_r[i] <= {AXI_DATA_WIDTH{1'b0}};
      end
    end else if (pop_s && pop_in_range_s) begin
      for (int i = 0; i < NLANE; i++) begin
        if (pop_strb_s[i]) begin
          mem_r[pop_idx_s[OPT_MEM_ADDR_BITS-1:0]][i*8 +: 8] <= pop_data_s[i*8 +: 8];
        end
      end
    end
  end

  // Registered read port; out-of-range reads return zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= {AXI_DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_accept_s;
      if (rd_accept_s) begin
        rd_data_r <= rd_in_range_s ? mem_r[rd_idx_s[OPT_MEM_ADDR_BITS-1:0]]
                                   : {AXI_DATA_WIDTH{1'b0}};
      end
    end
  end

  assign rd_ready    = rd_ready_s;
  assign rd_data     = rd_data_r;
  assign rd_valid    = rd_valid_r;
  assign aw_ar_ready = aw_ar_ready_r;
  assign fifo_level  = level_r;
  assign overflow    = overflow_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: doc/axi_slave_wr_buffer_mem.md
Name: axi_slave_wr_buffer_mem

Overview:
Downstream consumer of the AXI slave write-channel stage. Accepts the registered write stream (write_data/write_strb/w_opt_addr/write_valid), buffers it in a FIFO, and drains it into a byte-strobed register memory. Provides a single-cycle-latency read port for the read-channel stage. Generates aw_ar_ready so the write stage only accepts a burst when the whole burst is guaranteed to fit.

Parameters:
AXI_DATA_WIDTH, 32, data width of write stream, memory words and read port
AXI_ADDR_WIDTH, 32, width of w_opt_addr and rd_addr (word addresses)
DATA_MEM_LENGTH, 16, number of memory words
OPT_MEM_ADDR_BITS, $clog2(DATA_MEM_LENGTH), memory index width
ADDR_LSB, $clog2(AXI_DATA_WIDTH/8), byte-to-word shift
ADDR_BASE_OFFSET, 0, byte base of region; subtracted (>>ADDR_LSB) from incoming word addresses
FIFO_DEPTH, 16, write buffer entries; must be >= MAX_BURST+1
MAX_BURST, 8, largest burst (awlen+1) the system issues

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
write_data  in  AXI_DATA_WIDTH  write word
write_strb  in  4  byte enables
w_opt_addr  in  AXI_ADDR_WIDTH  word address including base offset
write_valid  in  1  one-cycle pulse per write; no backpressure
aw_ar_ready  out  1  permission for the write stage to accept a new AW
rd_en  in  1  read request
rd_addr  in  AXI_ADDR_WIDTH  read word address including base offset
rd_ready  out  1  read request accepted this cycle when rd_en=1
rd_data  out  AXI_DATA_WIDTH  read result
rd_valid  out  1  rd_data valid, one-cycle pulse
fifo_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
overflow  out  1  sticky: a write was lost because the FIFO was full
drop_cnt  out  8  saturating count of drained entries that had out-of-range addresses

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers and level are 0; FSM is IDLE.
  - All memory words are 0.
  - aw_ar_ready=0, rd_data=0, rd_valid=0, overflow=0, drop_cnt=0.
  - rd_ready takes its combinational value: 1 without the macro; 1 with the macro, since the FIFO is empty.
  - Reset mid-burst discards all buffered writes.
- Push:
  - Each write_valid pushes {index, data, strb}, where index = w_opt_addr - (ADDR_BASE_OFFSET>>ADDR_LSB).
  - Push succeeds when level<FIFO_DEPTH, or when level==FIFO_DEPTH and a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set (it stays set until reset).
- Drain FSM (registered):
  - IDLE: entered when level==0.
  - DRAIN: pops one entry per cycle.
  - STALL: entered when the memory port is taken by a read.
  - Transitions: IDLE->DRAIN when level>0; DRAIN->STALL on an accepted read; STALL->DRAIN when there is no accepted read and level>0; STALL->IDLE when there is no accepted read and level==0; DRAIN->IDLE when the last entry pops with no push in the same cycle.
- Pop/write:
  - Memory is single-port; an accepted read (rd_en && rd_ready) has priority, and no pop happens that cycle.
  - On pop, if index<DATA_MEM_LENGTH, each byte lane i with strb[i]=1 is written and other lanes are kept.
  - If index>=DATA_MEM_LENGTH, the entry is consumed with no memory write and drop_cnt increments, saturating at 255.
- Read:
  - On an accepted read, rd_data is registered next cycle with mem[rd_addr index] and rd_valid=1 for one cycle.
  - An out-of-range read returns 0 with rd_valid=1.
  - Without the macro, a read of an address still pending in the FIFO returns the old memory contents (no forwarding).
- aw_ar_ready:
  - Registered: next value = (FIFO_DEPTH - level_next) >= MAX_BURST+1, where level_next includes this cycle's push and pop.
  - The +1 covers the one-cycle write_valid pipeline of the write stage.
  - First cycle after reset release: aw_ar_ready=1.
- Simultaneous push and pop: level is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro WR_BUF_RAW_ORDER_EN.
- Defined: rd_ready = (level==0 && FSM==IDLE). A read waits until all earlier writes are in memory, so reads never return stale data. Reads therefore never stall the drain.
- Undefined: rd_ready=1 always and reads preempt the drain, with stale reads possible as described above.

Test Plan:
- Reset, then three writes to indices 0,1,2 with strb=4'hF, data 0x11111111/0x22222222/0x33333333, then idle -> memory holds those values; fifo_level returns to 0 within 4 cycles after the last push; aw_ar_ready=1 throughout.
- Write 0xAABBCCDD to index 3 with strb=4'hF, then 0x00000055 with strb=4'b0001 -> read of index 3 returns 0xAABBCC55 one cycle after rd_en.
- Hold rd_en=1 continuously (macro off) while pushing 9 writes -> level reaches 9; aw_ar_ready drops to 0 once free<9 (FIFO_DEPTH=16, MAX_BURST=8); releasing rd_en drains the FIFO and aw_ar_ready returns to 1.
- Push 17 writes with the drain blocked -> 17th write is dropped, overflow=1, level=16.
- Write to index 20 with DATA_MEM_LENGTH=16 -> memory unchanged, drop_cnt=1; read of index 20 returns rd_data=0 with rd_valid=1.
- Macro on: push a write to index 5, assert rd_en for index 5 in the next cycle -> rd_ready stays 0 until the FIFO is empty, and the read returns the new data.
